// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
// Shared types and constants for the pulse_meter block and its helpers.
//   DEFAULT_WIDTH : default counter / result field width
//   MAX_WIDTH     : widest counter the saturation constant can cover
//   SAT_ONES      : all-ones saturation constant; slice [W-1:0] for a W-bit counter
//   state_t       : measurement FSM states (ARM, HIGH, LOW)
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_WIDTH     = 32;

  // Counters clip at all-ones. A W-bit counter uses SAT_ONES[W-1:0].
  localparam logic [MAX_WIDTH-1:0] SAT_ONES = '1;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_meter_if.sv
// -----------------------------------------------------------------------------
// pulse_meter_if
// Result port of pulse_meter: valid/ready handshake plus measurement fields.
//   meas_valid  : producer -> consumer, result holds an unconsumed measurement
//   meas_ready  : consumer -> producer, accepts result when both are high
//   high_time   : cycles the input was sampled 1
//   low_time    : cycles the input was sampled 0
//   period      : high_time + low_time, one bit wider so it never wraps
//   saturated   : a counter clipped during this measurement
//   overrun     : sticky, a measurement was dropped (cleared by reset only)
// Modports: master = pulse_meter side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pulse_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             meas_valid;
  logic             meas_ready;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] low_time;
  logic [WIDTH:0]   period;
  logic             saturated;
  logic             overrun;

  modport master (
    output meas_valid,
    output high_time,
    output low_time,
    output period,
    output saturated,
    output overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  high_time,
    input  low_time,
    input  period,
    input  saturated,
    input  overrun,
    output meas_ready
  );

endinterface

// File: rtl/pulse_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous single-bit input into the clock domain and flags its
// edges. SYNC_STAGES flops form the synchronizer; one further flop holds the
// previous synchronized value for edge detection.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; clears every flop
//   d     : asynchronous input
//   q     : synchronized level
//   rise  : q is 1 this cycle and was 0 the cycle before
//   fall  : q is 0 this cycle and was 1 the cycle before
// Rise and fall come out of the same chain, so both see identical latency and
// pulse widths measured between them are exact.
// -----------------------------------------------------------------------------
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign q    = r_sync[SYNC_STAGES-1];
  assign rise = q & ~r_prev;
  assign fall = ~q & r_prev;

endmodule

// File: rtl/pulse_meter.sv
// -----------------------------------------------------------------------------
// pulse_meter
// Measures high time, low time and period (in clock cycles) of every complete
// cycle of an asynchronous pulse train and publishes them on a valid/ready
// result port.
//   clock     : sole clock, rising edge
//   reset     : synchronous, active-high
//   signal_in : pulse train under measurement, asynchronous to clock
//   meas      : pulse_meter_if.master result port (see pulse_meter_if)
// Parameters:
//   WIDTH       : counter / result field width (period is WIDTH+1), <= 32
//   SYNC_STAGES : synchronizer depth, 2 or 3
// A cycle is measured rise-to-rise. The first rise after reset only arms the
// meter, so a partial first cycle is never reported.
// -----------------------------------------------------------------------------
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          signal_in,
  pulse_meter_if.master meas
);

  localparam logic [WIDTH-1:0] CNT_MAX = SAT_ONES[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic w_level;
  logic w_rise;
  logic w_fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clock(clock),
    .reset(reset),
    .d    (signal_in),
    .q    (w_level),
    .rise (w_rise),
    .fall (w_fall)
  );

  // ---------------------------------------------------------------------------
  // Measurement FSM and counters
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_lcnt;
  logic             r_sat;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_hcnt_next;
  logic [WIDTH-1:0] w_lcnt_next;
  logic             w_sat_next;
  logic             w_publish;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ARM;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hcnt  <= w_hcnt_next;
      r_lcnt  <= w_lcnt_next;
      r_sat   <= w_sat_next;
    end
  end

  // The edge that takes a transition already counts as the first cycle of the
  // new phase (counter loads 1), so no cycle is lost or double counted.
  always_comb begin
    w_state_next = r_state;
    w_hcnt_next  = r_hcnt;
    w_lcnt_next  = r_lcnt;
    w_sat_next   = r_sat;
    w_publish    = 1'b0;

    case (r_state)
      ARM: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_hcnt_next  = {{(WIDTH-1){1'b0}}, 1'b1};
          w_lcnt_next  = '0;
          w_sat_next   = 1'b0;
        end
      end

      HIGH: begin
        if (w_fall) begin
          w_state_next = LOW;
          w_lcnt_next  = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (w_level) begin
          if (r_hcnt == CNT_MAX) begin
            w_sat_next = 1'b1;
          end else begin
            w_hcnt_next = r_hcnt + 1'b1;
          end
        end
      end

      LOW: begin
        if (w_rise) begin
          // Cycle complete: hand the current counts to the result stage and
          // start the next measurement in the same edge.
          w_publish    = 1'b1;
          w_state_next = HIGH;
          w_hcnt_next  = {{(WIDTH-1){1'b0}}, 1'b1};
          w_lcnt_next  = '0;
          w_sat_next   = 1'b0;
        end else if (!w_level) begin
          if (r_lcnt == CNT_MAX) begin
            w_sat_next = 1'b1;
          end else begin
            w_lcnt_next = r_lcnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ARM;
        w_hcnt_next  = '0;
        w_lcnt_next  = '0;
        w_sat_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result registers and handshake
  // ---------------------------------------------------------------------------
  logic             r_valid;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH:0]   r_period;
  logic             r_saturated;
  logic             r_overrun;

  logic [WIDTH:0]   w_period_sum;

  assign w_period_sum = {1'b0, r_hcnt} + {1'b0, r_lcnt};

  // A publish wins over a plain accept on the same edge: if the consumer takes
  // the old result while a new one arrives, valid simply stays high with the
  // new fields. When the old result is still pending, the new one is dropped
  // so the fields never change under a waiting consumer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_high      <= '0;
      r_low       <= '0;
      r_period    <= '0;
      r_saturated <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_publish) begin
      if (!r_valid || meas.meas_ready) begin
        r_valid     <= 1'b1;
        r_high      <= r_hcnt;
        r_low       <= r_lcnt;
        r_period    <= w_period_sum;
        r_saturated <= r_sat;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && meas.meas_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign meas.meas_valid = r_valid;
  assign meas.high_time  = r_high;
  assign meas.low_time   = r_low;
  assign meas.period     = r_period;
  assign meas.saturated  = r_saturated;
  assign meas.overrun    = r_overrun;

endmodule

// File: tb/tb_pulse_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_meter
// Directed bench for pulse_meter. Two instances: a 16-bit meter for the main
// patterns and a 4-bit meter for counter saturation. Inputs change 1 time unit
// after a rising edge, so the next rising edge is the first to sample them;
// outputs are checked at the same point.
// With SYNC_STAGES=2 a rise first sampled at edge N is taken by the FSM at
// edge N+2, so a result appears after the third edge counting N as the first.
// -----------------------------------------------------------------------------
module tb_pulse_meter;

  logic clock = 1'b0;
  logic reset;
  logic sig16;
  logic sig4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pulse_meter_if #(.WIDTH(16)) m16 ();
  pulse_meter_if #(.WIDTH(4))  m4 ();

  pulse_meter #(
    .WIDTH      (16),
    .SYNC_STAGES(2)
  ) dut16 (
    .clock    (clock),
    .reset    (reset),
    .signal_in(sig16),
    .meas     (m16)
  );

  pulse_meter #(
    .WIDTH      (4),
    .SYNC_STAGES(2)
  ) dut4 (
    .clock    (clock),
    .reset    (reset),
    .signal_in(sig4),
    .meas     (m4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input int h, input int l, input int per, input int sat);
    check({tag, " high_time"}, 32'(m16.high_time), h);
    check({tag, " low_time"},  32'(m16.low_time),  l);
    check({tag, " period"},    32'(m16.period),    per);
    check({tag, " saturated"}, 32'(m16.saturated), sat);
  endtask

  task automatic check4(input string tag, input int h, input int l, input int per, input int sat);
    check({tag, " high_time"}, 32'(m4.high_time), h);
    check({tag, " low_time"},  32'(m4.low_time),  l);
    check({tag, " period"},    32'(m4.period),    per);
    check({tag, " saturated"}, 32'(m4.saturated), sat);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sig16 = 1'b0;
    sig4  = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    bit exp_v;
    bit exp_ov;

    reset = 1'b1;
    sig16 = 1'b0;
    sig4  = 1'b0;
    m16.meas_ready = 1'b1;
    m4.meas_ready  = 1'b1;

    // Reset state of both instances
    ticks(3);
    check("rst16 valid", 32'(m16.meas_valid), 0);
    check16("rst16", 0, 0, 0, 0);
    check("rst16 overrun", 32'(m16.overrun), 0);
    check("rst4 valid", 32'(m4.meas_valid), 0);
    check4("rst4", 0, 0, 0, 0);
    check("rst4 overrun", 32'(m4.overrun), 0);
    reset = 1'b0;

    // Idle low input: nothing ever published
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("idle valid c%0d", i), 32'(m16.meas_valid), 0);
    end
    check16("idle", 0, 0, 0, 0);
    check("idle overrun", 32'(m16.overrun), 0);

    // 4 high / 6 low, consumer always ready: one-cycle valid per period
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 10; k++) begin
        sig16 = (k < 4);
        tick();
        exp_v = (p >= 1) && (k == 2);
        check($sformatf("p46 valid p%0d k%0d", p, k), 32'(m16.meas_valid), 32'(exp_v));
        if (exp_v) check16($sformatf("p46 p%0d", p), 4, 6, 10, 0);
      end
    end

    // 1 high / 1 low toggling: a result every 2 cycles
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 2; k++) begin
        sig16 = (k == 0);
        tick();
        exp_v = (p >= 2) && (k == 0);
        check($sformatf("p11 valid p%0d k%0d", p, k), 32'(m16.meas_valid), 32'(exp_v));
        if (exp_v) check16($sformatf("p11 p%0d", p), 1, 1, 2, 0);
      end
    end

    // 5/5 with consumer stalled: first result held, later ones dropped
    do_reset();
    m16.meas_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 10; k++) begin
        sig16 = (k < 5);
        tick();
        exp_v  = (p >= 2) || ((p == 1) && (k >= 2));
        exp_ov = (p >= 3) || ((p == 2) && (k >= 2));
        check($sformatf("p55 valid p%0d k%0d", p, k), 32'(m16.meas_valid), 32'(exp_v));
        check($sformatf("p55 overrun p%0d k%0d", p, k), 32'(m16.overrun), 32'(exp_ov));
        if (exp_v) check16($sformatf("p55 p%0d k%0d", p, k), 5, 5, 10, 0);
      end
    end
    m16.meas_ready = 1'b1;
    tick();
    check("p55 consumed valid", 32'(m16.meas_valid), 0);
    check("p55 consumed overrun", 32'(m16.overrun), 1);

    // Saturation on the 4-bit meter: 20 high, 3 low, then rise
    do_reset();
    check("sat pre overrun16 cleared", 32'(m16.overrun), 0);
    sig4 = 1'b1;
    ticks(20);
    check("sat armed valid", 32'(m4.meas_valid), 0);
    sig4 = 1'b0;
    ticks(3);
    sig4 = 1'b1;
    ticks(2);
    check("sat valid before", 32'(m4.meas_valid), 0);
    tick();
    check("sat valid", 32'(m4.meas_valid), 1);
    check4("sat", 15, 3, 18, 1);
    tick();
    sig4 = 1'b0;
    ticks(6);
    sig4 = 1'b1;
    ticks(2);
    check("sat next valid before", 32'(m4.meas_valid), 0);
    tick();
    check("sat next valid", 32'(m4.meas_valid), 1);
    check4("sat next", 4, 6, 10, 0);

    // Reset in the middle of a LOW phase discards everything and re-arms
    do_reset();
    m16.meas_ready = 1'b0;
    sig16 = 1'b1;
    ticks(4);
    sig16 = 1'b0;
    ticks(6);
    sig16 = 1'b1;
    ticks(3);
    check("midrst pre valid", 32'(m16.meas_valid), 1);
    check16("midrst pre", 4, 6, 10, 0);
    tick();
    sig16 = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst valid", 32'(m16.meas_valid), 0);
    check16("midrst", 0, 0, 0, 0);
    check("midrst overrun", 32'(m16.overrun), 0);
    ticks(3);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 10; k++) begin
        sig16 = (k < 4);
        tick();
        exp_v = (p == 1) && (k >= 2);
        check($sformatf("midrst valid p%0d k%0d", p, k), 32'(m16.meas_valid), 32'(exp_v));
        if (exp_v) check16($sformatf("midrst p%0d k%0d", p, k), 4, 6, 10, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
